// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters (fetch, data) access to a
// single-port memory. Each access runs IDLE -> SERVE -> ACK, so a request
// seen in IDLE completes two cycles later with a one-cycle ack pulse.
module mem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2
   } state_t;

   // Port identifiers used for grant and last-grant bookkeeping.
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t            state_q;
   logic              last_grant_q;
   logic              grant_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] f_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              f_ack_q;
   logic              d_ack_q;

   logic              any_req;
   logic              grant_d;

   // Pick the winner among current requests; only consumed in IDLE.
   always_comb begin
      any_req = f_req | d_req;
      grant_d = PORT_F;
      if (f_req && d_req) begin
         if (FIXED_PRIO != 0) begin
            grant_d = PORT_F;
         end else begin
            grant_d = ~last_grant_q;
         end
      end else if (d_req) begin
         grant_d = PORT_D;
      end
   end

   // Access sequencer: latch payload at grant, capture read data, pulse ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_D;
         grant_q      <= PORT_F;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         f_rdata_q    <= '0;
         d_rdata_q    <= '0;
         f_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               if (any_req) begin
                  state_q      <= SERVE;
                  grant_q      <= grant_d;
                  last_grant_q <= grant_d;
                  if (grant_d == PORT_D) begin
                     addr_q  <= d_addr;
                     wdata_q <= d_wdata;
                     wr_q    <= d_we;
                  end else begin
                     // Fetch is read-only; write data is left as it was.
                     addr_q <= f_addr;
                     wr_q   <= 1'b0;
                  end
               end
            end
            SERVE: begin
               state_q <= ACK;
               if (!wr_q) begin
                  if (grant_q == PORT_D) begin
                     d_rdata_q <= mem_rdata;
                  end else begin
                     f_rdata_q <= mem_rdata;
                  end
               end
               f_ack_q <= (grant_q == PORT_F);
               d_ack_q <= (grant_q == PORT_D);
            end
            ACK: begin
               state_q <= IDLE;
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
            end
         endcase
      end
   end

   // The write strobe is gated by rst so a reset during SERVE cancels the write.
   assign mem_we    = (state_q == SERVE) && wr_q && !rst;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign f_ack     = f_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter, with a
// transaction-level reference model feeding a scoreboard queue that a
// separate monitor drains on every ack.
module tb_mem_arbiter;

   typedef struct {
      logic        port;   // 0 = fetch, 1 = data
      int          cyc;    // cycle in which the ack is expected
      logic [15:0] frd;    // expected f_rdata at that ack
      logic [15:0] drd;    // expected d_rdata at that ack
   } exp_t;

   logic        clk;
   logic        rst;

   // round-robin instance
   logic        f_req, d_req, d_we, f_ack, d_ack, mem_we, busy;
   logic [11:0] f_addr, d_addr, mem_addr;
   logic [15:0] d_wdata, f_rdata, d_rdata, mem_wdata, mem_rdata;

   // fixed-priority instance
   logic        f_req_fp, d_req_fp, d_we_fp, f_ack_fp, d_ack_fp, mem_we_fp, busy_fp;
   logic [11:0] f_addr_fp, d_addr_fp, mem_addr_fp;
   logic [15:0] d_wdata_fp, f_rdata_fp, d_rdata_fp, mem_wdata_fp, mem_rdata_fp;

   // memory preload port
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [15:0] pre_data;

   logic [15:0] tmem [4096];
   int          wcount = 0;
   int          cyc = 0;

   // reference model state
   logic [15:0] mmem [4096];
   logic        last_m;
   logic [15:0] frd_m, drd_m;
   int          nwrites_m;
   exp_t        scq[$];
   exp_t        fpq[$];
   logic [11:0] pool [8];

   logic        zero_chk, final_chk;
   int          checks = 0;
   int          errors = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .f_req(f_req_fp), .f_addr(f_addr_fp), .f_rdata(f_rdata_fp), .f_ack(f_ack_fp),
      .d_req(d_req_fp), .d_we(d_we_fp), .d_addr(d_addr_fp), .d_wdata(d_wdata_fp),
      .d_rdata(d_rdata_fp), .d_ack(d_ack_fp),
      .mem_we(mem_we_fp), .mem_addr(mem_addr_fp), .mem_wdata(mem_wdata_fp),
      .mem_rdata(mem_rdata_fp), .busy(busy_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // single-port memory behind the round-robin instance
   always @(posedge clk) begin
      if (mem_we) begin
         tmem[mem_addr] <= mem_wdata;
         wcount         <= wcount + 1;
      end else if (pre_we) begin
         tmem[pre_addr] <= pre_data;
      end
   end
   assign mem_rdata = tmem[mem_addr];

   // fixed-priority instance reads from an address-derived pattern
   function automatic logic [15:0] fp_data(input logic [11:0] a);
      return {4'h0, a} ^ 16'hA5A5;
   endfunction
   assign mem_rdata_fp = fp_data(mem_addr_fp);

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: drains both scoreboards and performs flagged state checks
   initial begin
      exp_t e;
      int   fp_we_seen;
      fp_we_seen = 0;
      forever begin
         @(negedge clk);
         if (mem_we_fp) fp_we_seen++;
         if (f_ack || d_ack) begin
            if (scq.size() == 0) begin
               cmp("main_unexpected_ack", {30'd0, f_ack, d_ack}, 32'd0);
            end else begin
               e = scq.pop_front();
               $display("ack main port=%s cyc=%0d f_rdata=%h d_rdata=%h",
                        d_ack ? "D" : "F", cyc, f_rdata, d_rdata);
               cmp("main_ack_port", {30'd0, f_ack, d_ack}, e.port ? 32'd1 : 32'd2);
               cmp("main_ack_cycle", 32'(cyc), 32'(e.cyc));
               cmp("main_f_rdata", 32'(f_rdata), 32'(e.frd));
               cmp("main_d_rdata", 32'(d_rdata), 32'(e.drd));
               cmp("main_busy_in_ack", 32'(busy), 32'd1);
            end
         end else if (scq.size() != 0 && cyc > scq[0].cyc) begin
            cmp("main_ack_timeout", 32'(cyc), 32'(scq[0].cyc));
            scq.delete(0);
         end
         if (f_ack_fp || d_ack_fp) begin
            if (fpq.size() == 0) begin
               cmp("fp_unexpected_ack", {30'd0, f_ack_fp, d_ack_fp}, 32'd0);
            end else begin
               e = fpq.pop_front();
               $display("ack fp   port=%s cyc=%0d f_rdata=%h d_rdata=%h",
                        d_ack_fp ? "D" : "F", cyc, f_rdata_fp, d_rdata_fp);
               cmp("fp_ack_port", {30'd0, f_ack_fp, d_ack_fp}, e.port ? 32'd1 : 32'd2);
               cmp("fp_ack_cycle", 32'(cyc), 32'(e.cyc));
               cmp("fp_f_rdata", 32'(f_rdata_fp), 32'(e.frd));
               cmp("fp_d_rdata", 32'(d_rdata_fp), 32'(e.drd));
            end
         end else if (fpq.size() != 0 && cyc > fpq[0].cyc) begin
            cmp("fp_ack_timeout", 32'(cyc), 32'(fpq[0].cyc));
            fpq.delete(0);
         end
         if (zero_chk) begin
            cmp("rst_f_ack", 32'(f_ack), 32'd0);
            cmp("rst_d_ack", 32'(d_ack), 32'd0);
            cmp("rst_mem_we", 32'(mem_we), 32'd0);
            cmp("rst_mem_addr", 32'(mem_addr), 32'd0);
            cmp("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            cmp("rst_f_rdata", 32'(f_rdata), 32'd0);
            cmp("rst_d_rdata", 32'(d_rdata), 32'd0);
            cmp("rst_busy", 32'(busy), 32'd0);
            cmp("rst_fp_busy", 32'(busy_fp), 32'd0);
            cmp("rst_fp_mem_wdata", 32'(mem_wdata_fp), 32'd0);
         end
         if (final_chk) begin
            cmp("write_count", 32'(wcount), 32'(nwrites_m));
            cmp("fp_write_count", 32'(fp_we_seen), 32'd0);
            cmp("main_pending", 32'(scq.size()), 32'd0);
            cmp("fp_pending", 32'(fpq.size()), 32'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_reset();
      last_m = 1'b1;
      frd_m  = '0;
      drd_m  = '0;
   endtask

   // One access in service order: update model memory / rdata, queue the ack.
   task automatic model_access(input logic is_d, input int ackc, input logic [11:0] fa,
                               input logic dwe, input logic [11:0] da, input logic [15:0] dwd);
      exp_t e;
      if (!is_d) begin
         frd_m = mmem[fa];
      end else if (dwe) begin
         mmem[da] = dwd;
         nwrites_m++;
      end else begin
         drd_m = mmem[da];
      end
      last_m = is_d;
      e.port = is_d;
      e.cyc  = ackc;
      e.frd  = frd_m;
      e.drd  = drd_m;
      scq.push_back(e);
   endtask

   task automatic set_req(input logic is_d, input logic v);
      if (is_d) d_req = v;
      else      f_req = v;
   endtask

   // Garble a port's payload once its access has been latched.
   task automatic scramble(input logic is_d);
      if (is_d) begin
         d_addr  = 12'($urandom);
         d_wdata = 16'($urandom);
         d_we    = 1'($urandom);
      end else begin
         f_addr = 12'($urandom);
      end
   endtask

   // A batch: one or two requests, the second possibly arriving k cycles late.
   task automatic run_batch(input logic pf, input logic pd, input int k, input logic dfirst,
                            input logic drop_early, input logic [11:0] fa, input logic dwe,
                            input logic [11:0] da, input logic [15:0] dwd);
      int   c, tend;
      logic two, first_d;
      c   = cyc;
      two = pf && pd;
      if (two) first_d = (k == 0) ? ~last_m : dfirst;
      else     first_d = pd;
      model_access(first_d, c + 2, fa, dwe, da, dwd);
      if (two) model_access(~first_d, c + 5, fa, dwe, da, dwd);
      f_addr  = fa;
      d_we    = dwe;
      d_addr  = da;
      d_wdata = dwd;
      tend    = two ? 5 : 2;
      for (int t = 0; t <= tend; t++) begin
         if (t == 0) begin
            set_req(first_d, 1'b1);
            if (two && k == 0) set_req(~first_d, 1'b1);
         end
         if (two && k > 0 && t == k) set_req(~first_d, 1'b1);
         if (t == 1) begin
            scramble(first_d);
            if (drop_early) set_req(first_d, 1'b0);
         end
         if (t == 2) set_req(first_d, 1'b0);
         if (t == 4) scramble(~first_d);
         if (t == 5) set_req(~first_d, 1'b0);
         step();
      end
   endtask

   initial begin
      int          c;
      logic [15:0] v;
      logic [11:0] a2;
      int          sel;

      pool = '{12'h000, 12'h010, 12'h020, 12'hFFF, 12'h7FF, 12'h123, 12'h800, 12'h3C0};
      rst = 1'b1;
      f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      f_req_fp = 0; f_addr_fp = '0; d_req_fp = 0; d_we_fp = 0; d_addr_fp = '0; d_wdata_fp = '0;
      pre_we = 0; pre_addr = '0; pre_data = '0;
      zero_chk = 0; final_chk = 0;
      nwrites_m = 0;
      model_reset();
      repeat (3) step();

      // preload the address pool while the arbiters are held in reset
      for (int i = 0; i < 8; i++) begin
         if (pool[i] == 12'h010)      v = 16'hBEEF;
         else if (pool[i] == 12'h020) v = 16'h0A0A;
         else                         v = 16'($urandom);
         mmem[pool[i]] = v;
         pre_we = 1'b1; pre_addr = pool[i]; pre_data = v;
         step();
      end
      pre_we = 1'b0;
      zero_chk = 1'b1;
      step();
      zero_chk = 1'b0;
      rst = 1'b0;
      model_reset();
      step();

      // both ports requesting continuously from reset: F, D, F, D
      c = cyc;
      f_addr = 12'h010; d_addr = 12'h7FF; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      for (int i = 0; i < 4; i++) model_access(~last_m, c + 2 + 3 * i, 12'h010, 1'b0, 12'h7FF, 16'h0);
      repeat (11) step();
      f_req = 1'b0; d_req = 1'b0;
      step();

      // fetch only, then data write and read-back at the top address
      run_batch(1, 0, 0, 0, 0, 12'h010, 0, 12'h000, 16'h0);
      run_batch(0, 1, 0, 0, 0, 12'h000, 1, 12'hFFF, 16'h1234);
      run_batch(0, 1, 0, 0, 0, 12'h000, 0, 12'hFFF, 16'h0);

      // fixed priority: fetch keeps winning while it keeps requesting
      c = cyc;
      f_addr_fp = 12'h100; d_addr_fp = 12'h200; d_we_fp = 1'b0;
      f_req_fp = 1'b1; d_req_fp = 1'b1;
      fpq.push_back('{port: 1'b0, cyc: c + 2,  frd: fp_data(12'h100), drd: 16'h0});
      fpq.push_back('{port: 1'b0, cyc: c + 5,  frd: fp_data(12'h101), drd: 16'h0});
      fpq.push_back('{port: 1'b0, cyc: c + 8,  frd: fp_data(12'h102), drd: 16'h0});
      fpq.push_back('{port: 1'b1, cyc: c + 11, frd: fp_data(12'h102), drd: fp_data(12'h200)});
      for (int t = 0; t < 12; t++) begin
         if (t == 2)  f_addr_fp = 12'h101;
         if (t == 5)  f_addr_fp = 12'h102;
         if (t == 8)  f_req_fp = 1'b0;
         if (t == 11) d_req_fp = 1'b0;
         step();
      end

      // reset during SERVE of a write: no write, no ack, reset values
      d_we = 1'b1; d_addr = 12'h020; d_wdata = 16'h5555; d_req = 1'b1;
      step();
      rst = 1'b1; zero_chk = 1'b1; d_req = 1'b0;
      step();
      rst = 1'b0; zero_chk = 1'b0;
      model_reset();
      step();
      run_batch(0, 1, 0, 0, 0, 12'h000, 0, 12'h020, 16'h0);

      // reset during ACK of a read: captured rdata clears
      c = cyc;
      f_addr = 12'h123; f_req = 1'b1;
      model_access(1'b0, c + 2, 12'h123, 1'b0, 12'h000, 16'h0);
      step();
      step();
      f_req = 1'b0; rst = 1'b1; zero_chk = 1'b1;
      step();
      rst = 1'b0; zero_chk = 1'b0;
      model_reset();
      step();

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         sel = int'($urandom_range(0, 2));
         a2  = pool[$urandom_range(0, 7)];
         run_batch(sel != 1, sel != 0, int'($urandom_range(0, 2)), 1'($urandom),
                   $urandom_range(0, 3) == 0, pool[$urandom_range(0, 7)], 1'($urandom),
                   a2, 16'($urandom));
         repeat ($urandom_range(0, 2)) step();
      end

      step();
      final_chk = 1'b1;
      step();
      final_chk = 1'b0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
